dmem_ctrl: RTL

Parametrised data-memory controller replacing the bare RAM instance at the system top. It decodes the processor's access_type into byte lanes and performs sign/zero extension on loads. It detects misaligned accesses and arbitrates a second word-wide loader/debug port against the CPU port. It sits between processor (wren/address_dmem/data/q_dmem/access_type) and an internal synchronous word array.

---
 rtl/dmem_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller with byte lanes, load extension and loader-port arbitration
// Optional feature macro: DMEM_MMIO_EN (top word index becomes a read-only cycle counter)
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] address_dmem,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [2:0]            access_type,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] q_dmem,
  output logic                  cpu_stall,
  output logic                  misalign,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-3:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  ld_ack
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;
  localparam logic [2:0] STARVE_LIMIT = 3'd4;

  typedef enum logic [1:0] {IDLE, LD_ACCESS, LD_ACK} state_t;

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("dmem_ctrl: lane logic requires DATA_WIDTH == 32");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_nxt;
  logic [2:0]            wait_cnt;
  logic [IW-1:0]         idx;
  logic [1:0]            off;
  logic                  cpu_req;
  logic                  cpu_go;
  logic                  bad;
  logic                  mmio_hit;
  logic                  cpu_we;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd_word;

  assign idx     = address_dmem[ADDR_WIDTH-1:2];
  assign off     = address_dmem[1:0];
  assign cpu_req = wren | rden;
  assign cpu_go  = cpu_req & ~cpu_stall;

  always_comb begin
    bad = 1'b0;
    unique case (access_type)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = (off != 2'b00);
      default:        bad = 1'b1;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    wd = data;
    unique case (access_type[1:0])
      2'b00: begin
        be = 4'b0001 << off;
        wd = {4{data[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << off;
        wd = {2{data[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = data;
      end
    endcase
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clock) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign mmio_hit = &idx;
  assign rd_word  = mmio_hit ? cycle_cnt : mem[idx];
`else
  assign mmio_hit = 1'b0;
  assign rd_word  = mem[idx];
`endif

  assign cpu_we = wren & cpu_go & ~bad & ~mmio_hit;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] o,
                                           input logic [2:0] t);
    logic [31:0] s;
    s = w >> {o, 3'b000};
    unique case (t)
      3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
      3'b100:  load_ext = {24'd0, s[7:0]};
      3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
      3'b101:  load_ext = {16'd0, s[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  // The loader grant cycle stalls the CPU as well, so the two write paths never collide.
  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    ld_ack    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld_req && wait_cnt == STARVE_LIMIT) begin
          cpu_stall = 1'b1;
          state_nxt = LD_ACCESS;
        end else if (ld_req && !cpu_req) begin
          state_nxt = LD_ACCESS;
        end
      end
      LD_ACCESS: begin
        cpu_stall = 1'b1;
        state_nxt = LD_ACK;
      end
      LD_ACK: begin
        ld_ack    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset || state != IDLE || !ld_req) begin
      wait_cnt <= '0;
    end else if (cpu_req && wait_cnt != STARVE_LIMIT) begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == LD_ACCESS && ld_we) begin
        mem[ld_addr] <= ld_wdata;
      end else if (cpu_we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_dmem   <= '0;
      misalign <= 1'b0;
      ld_rdata <= '0;
    end else begin
      misalign <= cpu_go & bad;
      if (rden && cpu_go) q_dmem <= bad ? '0 : load_ext(rd_word, off, access_type);
      if (state == LD_ACCESS && !ld_we) ld_rdata <= mem[ld_addr];
    end
  end

endmodule
